// File: rtl/ncl_wavefront_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ncl_wavefront_sequencer
// Brief    : Clocked DATA/NULL wavefront sequencer driving a dual-rail NCL stage
//            from a valid/ready source, with completion capture and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module ncl_wavefront_sequencer #(
    parameter int WIDTH       = 4,
    parameter int OWIDTH      = 1,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic [WIDTH-1:0]  ncl_t,
    output logic [WIDTH-1:0]  ncl_f,
    input  logic              ncl_ko,
    input  logic [OWIDTH-1:0] res_t,
    input  logic [OWIDTH-1:0] res_f,
    output logic              out_valid,
    output logic [OWIDTH-1:0] out_data,
    output logic              err_timeout,
    output logic              err_illegal,
    input  logic              err_clr,
    output logic              busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_data  = 2'd1;
    localparam logic [1:0] c_st_nullw = 2'd2;
    localparam logic [1:0] c_st_err   = 2'd3;

    localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] c_cnt_max  = {CW{1'b1}};

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [SYNC_STAGES-1:0] r_ko_sync;
    logic                   w_ko_s;
    logic                   w_res_complete;
    logic                   w_res_null;
    logic                   w_res_bad;
    logic                   w_cnt_last;
    logic                   w_load_rails;
    logic                   w_clear_rails;
    logic                   w_capture;
    logic                   w_set_timeout;
    logic                   w_set_illegal;
    logic                   w_clr_err;

    // ko is asynchronous to clk; idle stage requests data, so the chain resets high
    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_ko_sync <= '1;
                else        r_ko_sync <= ncl_ko;
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_ko_sync <= '1;
                else        r_ko_sync <= {r_ko_sync[SYNC_STAGES-2:0], ncl_ko};
            end
        end
    endgenerate

    assign w_ko_s         = r_ko_sync[SYNC_STAGES-1];
    assign w_res_complete = &(res_t | res_f);
    assign w_res_null     = ~|(res_t | res_f);
    assign w_res_bad      = |(res_t & res_f);
    assign w_cnt_last     = (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (in_valid && in_ready) w_state_nxt = c_st_data;
            end
            c_st_data: begin
                // an illegal result beats completion, completion beats timeout
                if (w_res_bad)                        w_state_nxt = c_st_err;
                else if (!w_ko_s && w_res_complete)   w_state_nxt = c_st_nullw;
                else if (w_cnt_last)                  w_state_nxt = c_st_err;
            end
            c_st_nullw: begin
                if (w_ko_s && w_res_null)             w_state_nxt = c_st_idle;
                else if (w_cnt_last)                  w_state_nxt = c_st_err;
            end
            c_st_err: begin
                if (err_clr)                          w_state_nxt = c_st_nullw;
            end
            default:                                  w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready      = 1'b0;
        busy          = (r_state != c_st_idle);
        w_load_rails  = 1'b0;
        w_clear_rails = 1'b0;
        w_capture     = 1'b0;
        w_set_timeout = 1'b0;
        w_set_illegal = 1'b0;
        w_clr_err     = 1'b0;
        case (r_state)
            c_st_idle: begin
                in_ready     = rst_n & w_ko_s & w_res_null;
                w_load_rails = in_valid & in_ready;
            end
            c_st_data: begin
                w_clear_rails = (w_state_nxt != c_st_data);
                if (w_res_bad)                        w_set_illegal = 1'b1;
                else if (!w_ko_s && w_res_complete)   w_capture     = 1'b1;
                else if (w_cnt_last)                  w_set_timeout = 1'b1;
            end
            c_st_nullw: begin
                w_clear_rails = 1'b1;
                w_set_timeout = (w_state_nxt == c_st_err);
            end
            c_st_err: begin
                w_clear_rails = 1'b1;
                w_clr_err     = err_clr;
            end
            default: w_clear_rails = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncl_t       <= '0;
            ncl_f       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            err_timeout <= 1'b0;
            err_illegal <= 1'b0;
            r_cnt       <= '0;
        end else begin
            out_valid <= w_capture;
            if (w_capture) out_data <= res_t;

            if (w_load_rails) begin
                ncl_t <= in_data;
                ncl_f <= ~in_data;
            end else if (w_clear_rails) begin
                ncl_t <= '0;
                ncl_f <= '0;
            end

            if (w_clr_err) begin
                err_timeout <= 1'b0;
                err_illegal <= 1'b0;
            end else begin
                err_timeout <= err_timeout | w_set_timeout;
                err_illegal <= err_illegal | w_set_illegal;
            end

            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (((r_state == c_st_data) || (r_state == c_st_nullw)) && (r_cnt != c_cnt_max))
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ncl_wavefront_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ncl_wavefront_sequencer
// Brief    : Self-checking bench with a behavioural threshold-gate stage model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ncl_wavefront_sequencer;

    localparam int WIDTH       = 4;
    localparam int OWIDTH      = 1;
    localparam int TIMEOUT     = 15;
    localparam int SYNC_STAGES = 2;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_data  = '0;
    logic              err_clr  = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  ncl_t, ncl_f;
    logic              ncl_ko;
    logic [OWIDTH-1:0] res_t, res_f;
    logic              out_valid;
    logic [OWIDTH-1:0] out_data;
    logic              err_timeout, err_illegal, busy;

    ncl_wavefront_sequencer #(
        .WIDTH(WIDTH), .OWIDTH(OWIDTH), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ncl_t(ncl_t), .ncl_f(ncl_f), .ncl_ko(ncl_ko),
        .res_t(res_t), .res_f(res_f), .out_valid(out_valid), .out_data(out_data),
        .err_timeout(err_timeout), .err_illegal(err_illegal), .err_clr(err_clr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stage: true rail is th34 (>=3 ones), false rail its dual-rail complement
    // (>=2 zeros), both with NCL hysteresis; results settle after 3 cycles.
    // mode: 0 normal, 1 stuck (null, ko=1), 2 both rails high, 3 stuck non-null.
    logic       y_t = 1'b0, y_f = 1'b0;
    logic [1:0] p_t = 2'b00, p_f = 2'b00;
    int         mode = 0;

    always @(posedge clk) begin
        y_t <= ($countones(ncl_t) >= 3) || (y_t && (ncl_t != 4'b0000));
        y_f <= ($countones(ncl_f) >= 2) || (y_f && (ncl_f != 4'b0000));
        p_t <= {p_t[0], y_t};
        p_f <= {p_f[0], y_f};
    end

    always_comb begin
        res_t  = p_t[1];
        res_f  = p_f[1];
        ncl_ko = ~(p_t[1] | p_f[1]);
        case (mode)
            1: begin res_t = 1'b0; res_f = 1'b0; ncl_ko = 1'b1; end
            2: begin res_t = 1'b1; res_f = 1'b1; end
            3: begin res_t = 1'b1; res_f = 1'b0; ncl_ko = 1'b0; end
            default: ;
        endcase
    end

    // Any change between two non-NULL rail words is a DATA->DATA transition.
    logic [WIDTH-1:0] prev_t = '0, prev_f = '0;
    int rail_viol = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if ((ncl_t & ncl_f) != '0) rail_viol++;
            if (((prev_t | prev_f) != '0) && ((ncl_t | ncl_f) != '0) &&
                ((prev_t != ncl_t) || (prev_f != ncl_f))) rail_viol++;
        end
        prev_t = ncl_t;
        prev_f = ncl_f;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_out(input logic [WIDTH-1:0] w);
        return $countones(w) >= 3;
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 60) begin step(); n++; end
        check(name, 32'(in_ready), 32'd1);
    endtask

    task automatic accept(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] nw;
        nw       = ~w;
        in_data  = w;
        in_valid = 1'b1;
        wait_ready("ready_before_accept");
        step();
        in_valid = 1'b0;
        check("rails_t_after_accept", 32'(ncl_t), 32'(w));
        check("rails_f_after_accept", 32'(ncl_f), 32'(nw));
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input logic exp);
        int n    = 0;
        bit leak = 0;
        accept(w);
        while (!out_valid && n < 60) begin
            if (in_ready) leak = 1;
            step();
            n++;
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
        check("out_data", 32'(out_data), 32'(exp));
        check("ready_low_in_txn", 32'(leak), 32'd0);
        step();
        check("out_valid_single_pulse", 32'(out_valid), 32'd0);
        check("rails_null_after_done", 32'({ncl_t, ncl_f}), 32'd0);
    endtask

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [WIDTH-1:0] w;
        int n;
        bit seen;

        vecs[0] = '{4'b1110, 1'b1};
        vecs[1] = '{4'b0011, 1'b0};
        vecs[2] = '{4'b0111, 1'b1};
        vecs[3] = '{4'b0000, 1'b0};
        vecs[4] = '{4'b1111, 1'b1};
        vecs[5] = '{4'b1000, 1'b0};

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ncl_t", 32'(ncl_t), 32'd0);
        check("rst_ncl_f", 32'(ncl_f), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_errs", 32'({err_timeout, err_illegal}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // table vectors, including back-to-back words
        for (int i = 0; i < 6; i++) send(vecs[i].data, vecs[i].exp);

        // randomized words against the reference function
        for (int i = 0; i < 12; i++) begin
            w = 4'($urandom_range(0, 15));
            send(w, ref_out(w));
        end

        // timeout: stage never responds
        mode = 1;
        step();
        accept(4'b1010);
        repeat (TIMEOUT - 1) step();
        check("timeout_not_early", 32'(err_timeout), 32'd0);
        step();
        check("timeout_set", 32'(err_timeout), 32'd1);
        check("timeout_rails_null", 32'({ncl_t, ncl_f}), 32'd0);
        check("timeout_busy", 32'(busy), 32'd1);
        check("timeout_in_ready", 32'(in_ready), 32'd0);
        repeat (3) step();
        check("timeout_sticky", 32'(err_timeout), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("timeout_cleared", 32'(err_timeout), 32'd0);
        check("clr_goes_nullw_busy", 32'(busy), 32'd1);
        step();
        check("nullw_to_idle", 32'(busy), 32'd0);
        repeat (5) step();
        mode = 0;

        // illegal result (both rails high) in DATA
        accept(4'b1111);
        mode = 2;
        step();
        check("illegal_set", 32'(err_illegal), 32'd1);
        check("illegal_no_timeout", 32'(err_timeout), 32'd0);
        check("illegal_rails_null", 32'({ncl_t, ncl_f}), 32'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid || !busy) seen = 1;
            step();
        end
        check("illegal_holds_err", 32'({seen, out_valid}), 32'd0);
        mode    = 0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("illegal_cleared", 32'(err_illegal), 32'd0);
        n = 0;
        while (busy && n < 60) begin step(); n++; end
        check("illegal_recovers_idle", 32'(busy), 32'd0);

        // asynchronous reset during DATA
        accept(4'b0110);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rails", 32'({ncl_t, ncl_f}), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_outs", 32'({in_ready, out_valid, out_data, err_timeout, err_illegal}), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();

        // in_ready held off while stage reports a non-NULL result in IDLE
        mode     = 3;
        in_data  = 4'b0111;
        in_valid = 1'b1;
        seen     = 0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (in_ready || busy) seen = 1;
            step();
        end
        check("holdoff_ready_low", 32'(seen), 32'd0);
        mode = 0;
        #1;
        check("holdoff_ko_s_lag0", 32'(in_ready), 32'd0);
        step();
        check("holdoff_ko_s_lag1", 32'(in_ready), 32'd0);
        step();
        check("holdoff_ready_rise", 32'(in_ready), 32'd1);
        send(4'b0111, 1'b1);

        check("rail_protocol", 32'(rail_viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got running, expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
